// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller and its
// wrap-bit pointers.
package fifo_pkg;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  typedef logic [PTR_W:0] ptr_t;

  // Occupancy between two (ptr_w+1)-bit wrap-bit pointers, modulo 2^(ptr_w+1).
  function automatic int unsigned occupancy(input int unsigned wr,
                                            input int unsigned rd,
                                            input int unsigned ptr_w);
    return (wr - rd) & ((32'd1 << (ptr_w + 1)) - 32'd1);
  endfunction
endpackage

// File: rtl/dpram.sv
// Dual-port RAM with an enable-gated, 1-cycle registered read port.
module dpram #(
  parameter int unsigned Width     = 8,
  parameter int unsigned Depth     = 8,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_wr,
  input  logic                 clk_rd,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [Width-1:0]     i_wr_data,
  input  logic                 i_wr_full,
  input  logic                 i_rd_en,
  input  logic [AddrWidth-1:0] i_rd_addr,
  input  logic                 i_rd_empty,
  output logic [Width-1:0]     o_rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_wr) begin
    if (i_wr_en && !i_wr_full) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk_rd) begin
    if (i_rd_en && !i_rd_empty) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: increments on i_inc, clears on rst or i_flush.
module fifo_ptr #(
  parameter int unsigned PtrWidth = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_flush,
  output logic [PtrWidth:0] o_ptr
);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= o_ptr + {{PtrWidth{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FWFT FIFO controller sequencing a dpram; the RAM output register acts as
// the head-of-FIFO slot, giving Depth+1 words of capacity.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned Depth          = DEPTH,
  parameter  int unsigned PtrWidth       = $clog2(Depth),
  parameter  int unsigned AlmostFullThr  = Depth - 2,
  parameter  int unsigned AlmostEmptyThr = 2,
  localparam int unsigned CntWidth       = $clog2(Depth + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic                i_flush,
  input  logic                i_ready,
  output logic                o_wr_en,
  output logic [PtrWidth-1:0] o_wr_ptr,
  output logic                o_rd_en,
  output logic [PtrWidth-1:0] o_rd_ptr,
  output logic                o_full,
  output logic                o_ram_empty,
  output logic                o_valid,
  output logic [CntWidth-1:0] o_count,
  output logic                o_almost_full,
  output logic                o_almost_empty,
  output logic                o_overflow
);

  localparam int unsigned OccWidth = PtrWidth + 1;

  logic [PtrWidth:0] wr_ptr;
  logic [PtrWidth:0] rd_ptr;
  logic [PtrWidth:0] ram_occ;
  logic              push_ok;
  logic              valid_q;
  logic              overflow_q;

  fifo_ptr #(.PtrWidth(PtrWidth)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (push_ok),
    .i_flush (i_flush),
    .o_ptr   (wr_ptr)
  );

  fifo_ptr #(.PtrWidth(PtrWidth)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (o_rd_en),
    .i_flush (i_flush),
    .o_ptr   (rd_ptr)
  );

  assign ram_occ = OccWidth'(occupancy(32'(wr_ptr), 32'(rd_ptr), PtrWidth));

  // Flags come from registered pointers only: a same-cycle pop never frees
  // room for a push.
  assign o_full      = (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]) &&
                       (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]);
  assign o_ram_empty = (wr_ptr == rd_ptr);

  assign push_ok  = i_push && !o_full && !i_flush && !rst;
  assign o_wr_en  = push_ok;
  assign o_rd_en  = !rst && !i_flush && !o_ram_empty && (!valid_q || i_ready);
  assign o_wr_ptr = wr_ptr[PtrWidth-1:0];
  assign o_rd_ptr = rd_ptr[PtrWidth-1:0];

  assign o_valid        = valid_q;
  assign o_count        = CntWidth'(ram_occ) + CntWidth'(valid_q);
  assign o_almost_full  = ram_occ >= OccWidth'(AlmostFullThr);
  assign o_almost_empty = o_count <= CntWidth'(AlmostEmptyThr);
  assign o_overflow     = overflow_q;

  // Slot holds its word while the consumer stalls, since no fetch is issued.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      valid_q <= 1'b0;
    end else if (o_rd_en) begin
      valid_q <= 1'b1;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (i_push && o_full) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl + dpram: vector table for the basic sequences, an
// occupancy-level model for the corner cases, and a data scoreboard.
module tb_fifo_ctrl;
  localparam int Depth    = 8;
  localparam int PtrWidth = 3;
  localparam int CntWidth = 4;

  logic                clk = 1'b0;
  logic                rst, i_push, i_flush, i_ready;
  logic [7:0]          wr_data, rd_data;
  logic                o_wr_en, o_rd_en, o_full, o_ram_empty, o_valid;
  logic                o_almost_full, o_almost_empty, o_overflow;
  logic [PtrWidth-1:0] o_wr_ptr, o_rd_ptr;
  logic [CntWidth-1:0] o_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst, push, flush, ready;
    logic [7:0] data;
    int         count;
    logic       valid, full, af, ae, wr_en, rd_en, ovf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         m_occ, m_valid, m_ovf;

  always #5 clk = ~clk;

  fifo_ctrl #(.Depth(Depth)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_push         (i_push),
    .i_flush        (i_flush),
    .i_ready        (i_ready),
    .o_wr_en        (o_wr_en),
    .o_wr_ptr       (o_wr_ptr),
    .o_rd_en        (o_rd_en),
    .o_rd_ptr       (o_rd_ptr),
    .o_full         (o_full),
    .o_ram_empty    (o_ram_empty),
    .o_valid        (o_valid),
    .o_count        (o_count),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow)
  );

  dpram #(.Width(8), .Depth(Depth)) u_ram (
    .clk_wr     (clk),
    .clk_rd     (clk),
    .i_wr_en    (o_wr_en),
    .i_wr_addr  (o_wr_ptr),
    .i_wr_data  (wr_data),
    .i_wr_full  (o_full),
    .i_rd_en    (o_rd_en),
    .i_rd_addr  (o_rd_ptr),
    .i_rd_empty (o_ram_empty),
    .o_rd_data  (rd_data)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic r, p, f, rd, input logic [7:0] d,
                             input int cnt, input logic vl, fu, af, ae,
                             input logic we, re, ov);
    vec_t e;
    e.rst = r; e.push = p; e.flush = f; e.ready = rd; e.data = d;
    e.count = cnt; e.valid = vl; e.full = fu; e.af = af; e.ae = ae;
    e.wr_en = we; e.rd_en = re; e.ovf = ov;
    return e;
  endfunction

  // Expected outputs for the next cycle from the occupancy-level model.
  function automatic vec_t mk(input logic r, p, f, rd, input logic [7:0] d);
    vec_t e;
    e.rst = r; e.push = p; e.flush = f; e.ready = rd; e.data = d;
    e.count = m_occ + m_valid;
    e.valid = (m_valid != 0);
    e.full  = (m_occ == Depth);
    e.af    = (m_occ >= Depth - 2);
    e.ae    = (e.count <= 2);
    e.wr_en = p && !e.full && !f && !r;
    e.rd_en = !r && !f && (m_occ != 0) && (!e.valid || rd);
    e.ovf   = (m_ovf != 0);
    return e;
  endfunction

  // Drive one cycle (called at posedge+1), compare at the negedge, then
  // advance the model and scoreboard from the expected values.
  task automatic step(input vec_t e, input string tag);
    rst = e.rst; i_push = e.push; i_flush = e.flush; i_ready = e.ready;
    wr_data = e.data;
    #4;
    check({tag, ".count"}, int'(o_count), e.count);
    check({tag, ".valid"}, int'(o_valid), int'(e.valid));
    check({tag, ".full"}, int'(o_full), int'(e.full));
    check({tag, ".ram_empty"}, int'(o_ram_empty), int'((e.count - int'(e.valid)) == 0));
    check({tag, ".almost_full"}, int'(o_almost_full), int'(e.af));
    check({tag, ".almost_empty"}, int'(o_almost_empty), int'(e.ae));
    check({tag, ".wr_en"}, int'(o_wr_en), int'(e.wr_en));
    check({tag, ".rd_en"}, int'(o_rd_en), int'(e.rd_en));
    check({tag, ".overflow"}, int'(o_overflow), int'(e.ovf));
    if (o_valid) begin
      if (sb.size() == 0) check({tag, ".sb_empty"}, 1, 0);
      else check({tag, ".rd_data"}, int'(rd_data), int'(sb[0]));
    end
    if (e.rst || e.flush) begin
      sb.delete();
    end else begin
      if (e.valid && e.ready) void'(sb.pop_front());
      if (e.wr_en) sb.push_back(e.data);
    end
    if (e.rst) begin
      m_occ = 0; m_valid = 0; m_ovf = 0;
    end else begin
      if (e.push && e.full) m_ovf = 1;
      if (e.flush) begin
        m_occ = 0; m_valid = 0;
      end else begin
        m_occ   = m_occ + int'(e.wr_en) - int'(e.rd_en);
        m_valid = e.rd_en ? 1 : int'(e.valid && !e.ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input logic r, p, f, rd, input logic [7:0] d, input string tag);
    step(mk(r, p, f, rd, d), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset/idle, single push of 0xA, mid-run reset.
    tbl.push_back(v(0,0,0,0,8'h00, 0,0,0,0,1, 0,0,0));
    tbl.push_back(v(0,0,0,0,8'h00, 0,0,0,0,1, 0,0,0));
    tbl.push_back(v(0,1,0,0,8'h0A, 0,0,0,0,1, 1,0,0));
    tbl.push_back(v(0,0,0,0,8'h00, 1,0,0,0,1, 0,1,0));
    tbl.push_back(v(0,0,0,0,8'h00, 1,1,0,0,1, 0,0,0));
    tbl.push_back(v(0,0,0,0,8'h00, 1,1,0,0,1, 0,0,0));
    tbl.push_back(v(1,0,0,0,8'h00, 1,1,0,0,1, 0,0,0));
    tbl.push_back(v(0,0,0,0,8'h00, 0,0,0,0,1, 0,0,0));
    // Push words 0..9 with the consumer stalled; word 9 hits full.
    for (int k = 0; k < 10; k++) begin
      int occ;
      occ = (k < 2) ? k : k - 1;
      tbl.push_back(v(0,1,0,0,8'(k), k, k >= 2, k == 9, occ >= 6, k <= 2,
                      k != 9, k == 1, 0));
    end
    tbl.push_back(v(0,0,0,0,8'h00, 9,1,1,1,0, 0,0,1));
    // Pop everything; the first pop carries a push that full must reject.
    for (int p = 0; p < 9; p++) begin
      tbl.push_back(v(0, p == 0, 0, 1, 8'h77, 9 - p, 1, p == 0, (8 - p) >= 6,
                      (9 - p) <= 2, 0, p < 8, 1));
    end
    tbl.push_back(v(0,0,0,1,8'h00, 0,0,0,0,1, 0,0,1));

    rst = 1'b1; i_push = 1'b0; i_flush = 1'b0; i_ready = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    m_occ = 0; m_valid = 0; m_ovf = 0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Flush with 5 stored words and a same-cycle push; overflow stays set.
    for (int i = 0; i < 5; i++) mstep(0, 1, 0, 0, 8'(8'h20 + i), "flush_fill");
    mstep(0, 1, 1, 0, 8'h55, "flush");
    mstep(0, 0, 0, 0, 8'h00, "post_flush");
    mstep(0, 1, 0, 0, 8'h03, "push3");
    mstep(0, 0, 0, 0, 8'h00, "push3_fetch");
    mstep(0, 0, 0, 0, 8'h00, "push3_valid");

    // Mid-operation reset while a word sits in the slot.
    mstep(1, 0, 0, 0, 8'h00, "mid_rst");
    mstep(0, 0, 0, 0, 8'h00, "after_rst");

    // Streaming: simultaneous push/pop, pointers wrap several times.
    for (int i = 0; i < 40; i++) mstep(0, 1, 0, 1, 8'(8'h40 + i), "stream");
    for (int i = 0; i < 3; i++) mstep(0, 0, 0, 1, 8'h00, "stream_drain");

    // Almost-full at occupancy 6, then drain through almost-empty.
    for (int i = 0; i < 7; i++) mstep(0, 1, 0, 0, 8'(8'h90 + i), "thr_fill");
    mstep(0, 0, 0, 0, 8'h00, "thr_hold");
    for (int i = 0; i < 9; i++) mstep(0, 0, 0, 1, 8'h00, "thr_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
